gclk_mon_lcar_m5353q: RTL
=========================

// Module: gclk_mon_lcar_m5353Q
// PURPOSE
//  Receive-side monitor for the LED-driver grayscale clock (GCLK) burst interface.
//  Samples blank and gclk as seen at the driver pins in the clk domain, and segments time on blank.
//  Per segment: counts GCLK rising edges, measures post-burst dead time, and flags count,
//  dead-time and timeout violations. Used on the receiver board for bring-up and in-field
//  self-check of the MBI5051B drive path.
// PARAMETERS
//  EXP_GCLK     256    required GCLK rising edges per segment (14b gray, 1024 xgclk / 4)
//  MIN_DEAD     8      min clk cycles with no gclk edge between last edge and blank rise
//  TIMEOUT_CYC  65535  clk cycles with no gclk edge in COUNT before forced close (<= 65535)
// PORTS
//  clk            in   1   system clock, 25MHz, only clock; gclk period must be >= 4 clk
//  xrst           in   1   synchronous active-low reset
//  en             in   1   monitor enable (tie to gclkout_start)
//  clr_err        in   1   clears sticky error flags and err_total
//  blank          in   1   async, blank as driven to LED drivers
//  gclk           in   1   async, gclk as driven to LED drivers
//  seg_valid      out  1   1-clk pulse: segment closed, seg_* updated
//  seg_gclk_cnt   out  12  rising edges in last closed segment, saturates at 4095
//  seg_dead_cnt   out  16  clk cycles from last gclk edge to close, saturates at 65535
//  err_cnt_mis    out  1   sticky: a segment closed with seg_gclk_cnt != EXP_GCLK
//  err_dead_short out  1   sticky: a segment closed with seg_dead_cnt < MIN_DEAD
//  err_timeout    out  1   sticky: a segment was closed by timeout
//  err_total      out  8   count of bad segments, saturates at 255
// BEHAVIOUR
//  - Reset (xrst=0 at clk edge): state IDLE, all outputs and counters 0.
//  - blank and gclk each pass through 2-FF sync plus 1 delay reg. Edge pulses come from the
//    synced value vs the delayed value. Pin-to-edge-pulse latency is 3 clk.
//  - FSM states: IDLE, ARMED, COUNT, REPORT.
//    IDLE:   en=1 -> ARMED.
//    ARMED:  blank falling edge -> COUNT, and gclk_cnt<=0, idle_cnt<=0. All gclk edges are ignored.
//    COUNT:  each gclk rising edge increments gclk_cnt (saturating).
//            Any gclk edge (rising or falling) sets idle_cnt<=0; otherwise idle_cnt increments (saturating).
//            blank rising edge -> REPORT (normal close).
//            idle_cnt==TIMEOUT_CYC -> REPORT with timeout mark (checked after blank rise;
//            blank rise takes priority in the same cycle).
//    REPORT: 1 cycle. seg_valid=1, seg_gclk_cnt<=gclk_cnt, seg_dead_cnt<=idle_cnt.
//            Error evaluation happens here. Next state is ARMED.
//    en=0 in any state -> IDLE next cycle. An open segment is discarded with no seg_valid,
//    and seg_* hold their values.
//  - seg_valid is asserted 1 clk after the close event is detected, so 4 clk after the pin edge.
//    seg_* change only in REPORT.
//  - Segment is bad if the count mismatches, the dead time is short, or the segment timed out.
//    Each bad segment sets the matching sticky flags and increments err_total by 1.
//  - A timeout close skips the dead-time check (idle_cnt=TIMEOUT_CYC).
//  - clr_err=1 zeroes flags and err_total. If REPORT flags a bad segment in the same cycle,
//    the clear applies first, giving flag=1 and err_total=1.
//  - A blank falling edge while in COUNT (glitch, no rise seen) is ignored. Counting continues.
//  - gclk edges in REPORT are lost; a compliant source has none (dead time >= MIN_DEAD).
// TESTING
//  1 en=1, blank pulse, 256 gclk (period 8 clk), blank rises 40 clk after last edge
//    -> seg_valid once, seg_gclk_cnt=256, seg_dead_cnt=36..40, all err=0.
//  2 Same but 255 pulses -> err_cnt_mis=1, err_total=1; next segment with 256 -> err_total stays 1.
//  3 256 pulses, blank rises 3 clk after last gclk edge -> err_dead_short=1, err_total=1.
//  4 blank falls, 10 pulses, gclk stuck for TIMEOUT_CYC=100 (override)
//    -> seg_valid, seg_gclk_cnt=10, err_timeout=1. Later blank rise gives no seg_valid.
//  5 en dropped mid-COUNT after 100 pulses -> no seg_valid, seg_* keep prior values.
//    Re-enable, full segment -> normal report.
//  6 clr_err coincident with bad REPORT when err_total=5 -> err_total=1.
//    xrst=0 mid-COUNT -> all outputs 0 next clk.

Source files
------------

// File: rtl/gclk_mon_lcar_m5353q_if.sv
// Segment report bus of the GCLK burst monitor.
// The monitor drives it; the host/self-check logic consumes it.
interface gclk_mon_lcar_m5353q_if;
  logic        seg_valid;
  logic [11:0] seg_gclk_cnt;
  logic [15:0] seg_dead_cnt;
  logic        err_cnt_mis;
  logic        err_dead_short;
  logic        err_timeout;
  logic [7:0]  err_total;

  modport master (
    output seg_valid,
    output seg_gclk_cnt,
    output seg_dead_cnt,
    output err_cnt_mis,
    output err_dead_short,
    output err_timeout,
    output err_total
  );

  modport slave (
    input seg_valid,
    input seg_gclk_cnt,
    input seg_dead_cnt,
    input err_cnt_mis,
    input err_dead_short,
    input err_timeout,
    input err_total
  );
endinterface

// File: rtl/gclk_mon_lcar_m5353q.sv
// Receive-side GCLK burst monitor: segments time on blank,
// counts GCLK edges and dead time, keeps sticky error flags.
module gclk_mon_lcar_m5353q #(
  parameter int unsigned EXP_GCLK    = 256,
  parameter int unsigned MIN_DEAD    = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic xrst,
  input  logic en,
  input  logic clr_err,
  input  logic blank,
  input  logic gclk,
  gclk_mon_lcar_m5353q_if.master rpt
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNT,
    REPORT
  } state_t;

  localparam logic [11:0] EXP = 12'(EXP_GCLK);
  localparam logic [15:0] MIN = 16'(MIN_DEAD);
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

  state_t state;
  state_t state_nxt;

  logic blank_s1;
  logic blank_s2;
  logic blank_d;
  logic gclk_s1;
  logic gclk_s2;
  logic gclk_d;

  logic [11:0] gclk_cnt;
  logic [15:0] idle_cnt;
  logic        seg_tmo;

  logic blank_rise;
  logic blank_fall;
  logic gclk_rise;
  logic gclk_edge;
  logic timeout_hit;

  logic       bad_mis;
  logic       bad_short;
  logic       bad;
  logic [7:0] base_total;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      blank_s1 <= 1'b0;
      blank_s2 <= 1'b0;
      blank_d  <= 1'b0;
      gclk_s1  <= 1'b0;
      gclk_s2  <= 1'b0;
      gclk_d   <= 1'b0;
    end else begin
      blank_s1 <= blank;
      blank_s2 <= blank_s1;
      blank_d  <= blank_s2;
      gclk_s1  <= gclk;
      gclk_s2  <= gclk_s1;
      gclk_d   <= gclk_s2;
    end
  end

  assign blank_rise = blank_s2 & ~blank_d;
  assign blank_fall = ~blank_s2 & blank_d;
  assign gclk_rise  = gclk_s2 & ~gclk_d;
  assign gclk_edge  = gclk_s2 ^ gclk_d;

  // blank rise wins over a timeout in the same cycle
  assign timeout_hit = (idle_cnt == TMO) && !blank_rise;

  always_ff @(posedge clk) begin
    if (!xrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = ARMED;
      ARMED:  if (blank_fall) state_nxt = COUNT;
      COUNT:  if (blank_rise || timeout_hit) state_nxt = REPORT;
      REPORT: state_nxt = ARMED;
    endcase
    if (!en) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      gclk_cnt <= '0;
      idle_cnt <= '0;
      seg_tmo  <= 1'b0;
    end else if (state == ARMED && blank_fall) begin
      gclk_cnt <= '0;
      idle_cnt <= '0;
      seg_tmo  <= 1'b0;
    end else if (state == COUNT) begin
      seg_tmo <= timeout_hit;
      if (!timeout_hit) begin
        if (gclk_rise && gclk_cnt != 12'hfff)
          gclk_cnt <= gclk_cnt + 12'd1;
        if (gclk_edge)
          idle_cnt <= '0;
        else if (idle_cnt != TMO)
          idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  assign bad_mis    = (gclk_cnt != EXP);
  assign bad_short  = !seg_tmo && (idle_cnt < MIN);
  assign bad        = bad_mis | bad_short | seg_tmo;
  assign base_total = clr_err ? 8'd0 : rpt.err_total;

  always_ff @(posedge clk) begin
    if (!xrst) begin
      rpt.seg_valid      <= 1'b0;
      rpt.seg_gclk_cnt   <= '0;
      rpt.seg_dead_cnt   <= '0;
      rpt.err_cnt_mis    <= 1'b0;
      rpt.err_dead_short <= 1'b0;
      rpt.err_timeout    <= 1'b0;
      rpt.err_total      <= '0;
    end else begin
      rpt.seg_valid <= (state == REPORT);
      if (state == REPORT) begin
        rpt.seg_gclk_cnt   <= gclk_cnt;
        rpt.seg_dead_cnt   <= idle_cnt;
        rpt.err_cnt_mis    <= (rpt.err_cnt_mis & ~clr_err) | bad_mis;
        rpt.err_dead_short <= (rpt.err_dead_short & ~clr_err) | bad_short;
        rpt.err_timeout    <= (rpt.err_timeout & ~clr_err) | seg_tmo;
        if (bad && base_total != 8'hff)
          rpt.err_total <= base_total + 8'd1;
        else
          rpt.err_total <= base_total;
      end else if (clr_err) begin
        rpt.err_cnt_mis    <= 1'b0;
        rpt.err_dead_short <= 1'b0;
        rpt.err_timeout    <= 1'b0;
        rpt.err_total      <= '0;
      end
    end
  end

endmodule
